cla_addsub_pipe: RTL

Parametrised, two-stage pipelined carry-lookahead adder/subtractor for the Execute stage; a successor to the fixed 4-bit CLA group.
- Builds a WIDTH-bit datapath from 4-bit lookahead groups.
- Splits the carry chain at WIDTH/2 with a registered carry.
- Adds subtract and optional signed saturation modes.
- Reports N/Z/V/C flags through a valid/ready streaming interface with full backpressure.

---
 rtl/cla_addsub_pipe.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe
// Two-stage pipelined carry-lookahead adder/subtractor with N/Z/V/C flags
// and a valid/ready streaming interface with full backpressure.
//
// The datapath is built from 4-bit lookahead groups. A second lookahead level
// combines the groups inside each half. The carry chain is split at WIDTH/2:
// - stage 1 adds the lower half and registers the carry out of bit WIDTH/2-1;
// - stage 2 adds the upper half from that registered carry.
//
// Parameters:
//   WIDTH      operand/result width (multiple of 8, minimum 8), default 16
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat offered
//   in_ready   block accepts beat this cycle
//   a, b       operands (two's complement)
//   op         00 ADD, 01 SUB, 10 ADDS (saturating), 11 SUBS (saturating)
//   out_valid  result beat offered
//   out_ready  consumer accepts result
//   sum        result
//   flags      {N, Z, V, C}
//
// Build option:
//   CLA_SAT_EN  when defined, ADDS/SUBS clamp to the signed range on overflow.
//               When undefined, the saturation mux is not built, ADDS acts
//               as ADD and SUBS acts as SUB.
//
// Handshake: a beat moves on either side only when valid && ready are both
// high at the rising edge. The valid signals never depend on the ready
// signals. in_ready depends combinationally on out_ready and does not depend
// on in_valid.
module cla_addsub_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [3:0]       flags
);

  localparam int HW = WIDTH / 2;  // bits per half
  localparam int NG = HW / 4;     // 4-bit groups per half

  // One half-width lookahead adder. It returns {carry_out, sum}.
  // Group carries are written in sum-of-products form over the group
  // generate/propagate terms, so no carry ripples from group to group.
  function automatic logic [HW:0] cla_half(input logic [HW-1:0] x,
                                           input logic [HW-1:0] y,
                                           input logic          cin);
    logic [HW-1:0] p;
    logic [HW-1:0] g;
    logic [HW-1:0] s;
    logic [NG-1:0] gp;
    logic [NG-1:0] gg;
    logic [NG:0]   gc;
    logic          term;
    logic          c;
    int            base;
    int            t;
    p = x ^ y;
    g = x & y;
    for (int j = 0; j < NG; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
    // Second lookahead level: carry into group j.
    gc[0] = cin;
    for (int j = 1; j <= NG; j++) begin
      term = cin;
      for (int m = 0; m < j; m++) term = term & gp[m];
      c = term;
      for (int k = 0; k < j; k++) begin
        term = gg[k];
        for (int m = k + 1; m < j; m++) term = term & gp[m];
        c = c | term;
      end
      gc[j] = c;
    end
    // First level: carry into each bit, formed from its own group carry-in.
    for (int i = 0; i < HW; i++) begin
      base = (i / 4) * 4;
      t    = i % 4;
      term = gc[i/4];
      for (int m = 0; m < t; m++) term = term & p[base+m];
      c = term;
      for (int k = 0; k < t; k++) begin
        term = g[base+k];
        for (int m = k + 1; m < t; m++) term = term & p[base+m];
        c = c | term;
      end
      s[i] = p[i] ^ c;
    end
    return {gc[NG], s};
  endfunction

  // ---------------- handshake ----------------
  logic adv1;
  logic adv2;
  logic s1_valid;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  // ---------------- stage 1 ----------------
  logic [WIDTH-1:0] b_eff;
  logic [HW:0]      lo_res;

  // For subtraction, invert B and use a carry-in of 1 (two's complement).
  assign b_eff  = op[0] ? ~b : b;
  assign lo_res = cla_half(a[HW-1:0], b_eff[HW-1:0], op[0]);

  logic [HW-1:0] s1_lo_sum;
  logic          s1_carry;
  logic [HW-1:0] s1_a_hi;
  logic [HW-1:0] s1_b_hi;
  logic [1:0]    s1_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_lo_sum <= '0;
      s1_carry  <= 1'b0;
      s1_a_hi   <= '0;
      s1_b_hi   <= '0;
      s1_op     <= 2'b00;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_lo_sum <= lo_res[HW-1:0];
        s1_carry  <= lo_res[HW];
        s1_a_hi   <= a[WIDTH-1:HW];
        s1_b_hi   <= b_eff[WIDTH-1:HW];
        s1_op     <= op;
      end
    end
  end

  // ---------------- stage 2 ----------------
  logic [HW:0]      hi_res;
  logic [WIDTH-1:0] raw;
  logic             raw_c;
  logic             raw_v;
  logic             a_msb;
  logic [WIDTH-1:0] fin;

  assign hi_res = cla_half(s1_a_hi, s1_b_hi, s1_carry);
  assign raw    = {hi_res[HW-1:0], s1_lo_sum};
  assign raw_c  = hi_res[HW];
  assign a_msb  = s1_a_hi[HW-1];
  // Signed overflow: operands with the same sign give a result of the other sign.
  assign raw_v  = (a_msb == s1_b_hi[HW-1]) && (raw[WIDTH-1] != a_msb);

`ifdef CLA_SAT_EN
  logic unused_op;
  assign unused_op = s1_op[0];

  // Clamp toward the sign of A. Only the saturating ops do this.
  always_comb begin
    fin = raw;
    if (s1_op[1] && raw_v) begin
      fin = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  logic unused_op;
  assign unused_op = ^s1_op;
  assign fin = raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      flags     <= 4'b0000;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum <= fin;
        // N and Z follow the final sum. V and C follow the raw result.
        flags <= {fin[WIDTH-1], (fin == '0), raw_v, raw_c};
      end
    end
  end

endmodule
